// File: rtl/sine_voice_scheduler_if.sv
// rtl/sine_voice_scheduler_if.sv - frame control, voice config, shared sinus core and mix output bundle
interface sine_voice_scheduler_if #(
  parameter int LOG2_N = 2
) ();
  logic              sample_tick;
  logic              cfg_we;
  logic [LOG2_N-1:0] cfg_ch;
  logic [13:0]       cfg_step;
  logic              cfg_en;
  logic              ovr_clr;
  logic [15:0]       core_phase;
  logic [15:0]       core_result;
  logic [15:0]       mix_out;
  logic              mix_valid;
  logic              busy;
  logic              overrun;

  modport master (
    output sample_tick, cfg_we, cfg_ch, cfg_step, cfg_en, ovr_clr, core_result,
    input  core_phase, mix_out, mix_valid, busy, overrun
  );

  modport slave (
    input  sample_tick, cfg_we, cfg_ch, cfg_step, cfg_en, ovr_clr, core_result,
    output core_phase, mix_out, mix_valid, busy, overrun
  );
endinterface

// File: rtl/sine_voice_scheduler.sv
// rtl/sine_voice_scheduler.sv - time-multiplexes one sinus core over N_CH voices and mixes them
// Optional macro MIX_SAT_EN: saturate the raw sum to 16 bits instead of dividing by N_CH.
module sine_voice_scheduler #(
  parameter int N_CH     = 4,
  parameter int LOG2_N   = 2,
  parameter int CORE_LAT = 4
) (
  input logic                  clk,
  input logic                  rst,
  sine_voice_scheduler_if.slave bus
);
  localparam logic [15:0] PH_MIN = 16'hE000;
  localparam logic [15:0] PH_MAX = 16'h2000;
  localparam int          CW     = $clog2(CORE_LAT + 1);
  localparam int          AW     = 16 + LOG2_N;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_DONE} state_t;

  state_t state, state_nxt;

  logic [15:0]        phase [N_CH];
  logic [13:0]        step  [N_CH];
  logic [N_CH-1:0]    en;
  logic [LOG2_N-1:0]  ch;
  logic [CW-1:0]      cnt;
  logic               en_lat;
  logic signed [AW-1:0] acc;
  logic [15:0]        core_phase_q;
  logic [15:0]        mix_out_q;
  logic               mix_valid_q;
  logic               busy_q;
  logic               overrun_q;
  logic [15:0]        mix_val;

  logic start, do_issue, do_wait, do_capture, do_done, ovr_set, last_ch;

  assign last_ch = (ch == LOG2_N'(N_CH - 1));

  function automatic logic [15:0] advance(input logic [15:0] p, input logic [13:0] st);
    logic [15:0] s;
    s = p + {2'b00, st};
    advance = ($signed(s) > $signed(PH_MAX)) ? (s - 16'h4000) : s;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (bus.sample_tick) state_nxt = S_ISSUE;
      S_ISSUE:   state_nxt = S_WAIT;
      S_WAIT:    if (cnt == CW'(1)) state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = last_ch ? S_DONE : S_ISSUE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    start      = (state == S_IDLE) && bus.sample_tick;
    do_issue   = (state == S_ISSUE);
    do_wait    = (state == S_WAIT);
    do_capture = (state == S_CAPTURE);
    do_done    = (state == S_DONE);
    ovr_set    = (state != S_IDLE) && bus.sample_tick;
  end

  // Config writes sit after the capture update so a same-cycle disable overrides the advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        phase[i] <= PH_MIN;
        step[i]  <= '0;
      end
      en <= '0;
    end else begin
      if (do_capture && en_lat && en[ch]) phase[ch] <= advance(phase[ch], step[ch]);
      if (bus.cfg_we) begin
        step[bus.cfg_ch] <= bus.cfg_step;
        en[bus.cfg_ch]   <= bus.cfg_en;
        if (!bus.cfg_en) phase[bus.cfg_ch] <= PH_MIN;
      end
    end
  end

`ifdef MIX_SAT_EN
  always_comb begin
    if (acc > $signed(AW'(32767)))       mix_val = 16'h7FFF;
    else if (acc < -$signed(AW'(32768))) mix_val = 16'h8000;
    else                                  mix_val = acc[15:0];
  end
`else
  logic signed [AW-1:0] acc_div;
  assign acc_div = acc >>> LOG2_N;
  assign mix_val = acc_div[15:0];
`endif

  // Enable is latched at issue so a voice disabled while its result is in flight still mixes in.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch           <= '0;
      cnt          <= '0;
      en_lat       <= 1'b0;
      acc          <= '0;
      core_phase_q <= PH_MIN;
      mix_out_q    <= '0;
      mix_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      mix_valid_q <= do_done;
      if (start) begin
        ch     <= '0;
        acc    <= '0;
        busy_q <= 1'b1;
      end
      if (do_issue) begin
        core_phase_q <= phase[ch];
        cnt          <= CW'(CORE_LAT);
        en_lat       <= en[ch];
      end
      if (do_wait) cnt <= cnt - CW'(1);
      if (do_capture) begin
        if (en_lat) acc <= acc + {{LOG2_N{bus.core_result[15]}}, bus.core_result};
        if (!last_ch) ch <= ch + LOG2_N'(1);
      end
      if (do_done) begin
        mix_out_q <= mix_val;
        busy_q    <= 1'b0;
      end
      if (ovr_set)          overrun_q <= 1'b1;
      else if (bus.ovr_clr) overrun_q <= 1'b0;
    end
  end

  assign bus.core_phase = core_phase_q;
  assign bus.mix_out    = mix_out_q;
  assign bus.mix_valid  = mix_valid_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_sine_voice_scheduler.sv
// tb/tb_sine_voice_scheduler.sv - directed and randomized frames against a per-frame arithmetic model
module tb_sine_voice_scheduler;
  localparam int N_CH = 4, LOG2_N = 2, CORE_LAT = 4;
  localparam int LAT  = N_CH * (CORE_LAT + 2) + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sine_voice_scheduler_if #(.LOG2_N(LOG2_N)) bus ();
  sine_voice_scheduler #(.N_CH(N_CH), .LOG2_N(LOG2_N), .CORE_LAT(CORE_LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0, passes = 0, fails = 0;

  // Behavioural sinus core: arbitrary affine map of the phase, CORE_LAT registers deep.
  logic [15:0] core_mul, core_add;
  logic [15:0] pipe [CORE_LAT];
  function automatic logic [15:0] core_fn(input logic [15:0] p);
    logic [31:0] t;
    t = p * core_mul + core_add;
    return t[15:0];
  endfunction
  always @(posedge clk) begin
    pipe[0] <= core_fn(bus.core_phase);
    for (int i = 1; i < CORE_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.core_result = pipe[CORE_LAT-1];

  logic [15:0] m_phase [N_CH];
  logic [13:0] m_step  [N_CH];
  logic        m_en    [N_CH];
  logic [15:0] exp_ph  [N_CH];
  logic [15:0] obs_ph  [N_CH];
  logic [15:0] exp_mix;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] adv(input logic [15:0] p, input logic [13:0] st);
    int s;
    s = int'($signed(p)) + int'(st);
    if (s > 8192) s -= 16384;
    return s[15:0];
  endfunction

  task automatic model_reset();
    for (int v = 0; v < N_CH; v++) begin
      m_phase[v] = 16'hE000;
      m_step[v]  = '0;
      m_en[v]    = 1'b0;
    end
  endtask

  task automatic model_frame();
    int acc;
    acc = 0;
    for (int v = 0; v < N_CH; v++) begin
      exp_ph[v] = m_phase[v];
      if (m_en[v]) begin
        acc += int'($signed(core_fn(m_phase[v])));
        m_phase[v] = adv(m_phase[v], m_step[v]);
      end
    end
`ifdef MIX_SAT_EN
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
`else
    acc = acc >>> LOG2_N;
`endif
    exp_mix = acc[15:0];
  endtask

  task automatic cfg_write(input int ch, input logic [13:0] st, input logic e);
    @(negedge clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_ch   = LOG2_N'(ch);
    bus.cfg_step = st;
    bus.cfg_en   = e;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    m_step[ch] = st;
    m_en[ch]   = e;
    if (!e) m_phase[ch] = 16'hE000;
  endtask

  // One frame; optionally a second tick at offset extra_at, optionally disabling voice 2 during its wait.
  task automatic run_frame(input int extra_at, input bit dis2);
    int got, pulses;
    got = 0;
    pulses = 0;
    model_frame();
    @(negedge clk);
    bus.sample_tick = 1'b1;
    for (int c = 1; c <= LAT + 12; c++) begin
      @(negedge clk);
      if (c == 1) check("busy_rise", bus.busy, 1'b1);
      for (int v = 0; v < N_CH; v++)
        if (c == 2 + 6 * v) begin
          obs_ph[v] = bus.core_phase;
          check($sformatf("issue_ph%0d", v), bus.core_phase, exp_ph[v]);
        end
      if (bus.mix_valid === 1'b1) begin
        pulses++;
        if (got == 0) begin
          got = c;
          check("mix_out", bus.mix_out, exp_mix);
          check("busy_fall", bus.busy, 1'b0);
        end
      end
      bus.sample_tick = (c == extra_at);
      bus.cfg_we      = dis2 && (c == 15);
      bus.cfg_ch      = LOG2_N'(2);
      bus.cfg_step    = m_step[2];
      bus.cfg_en      = 1'b0;
    end
    bus.sample_tick = 1'b0;
    bus.cfg_we      = 1'b0;
    check("latency", got, LAT);
    check("pulses", pulses, 1);
    if (dis2) begin
      m_en[2]    = 1'b0;
      m_phase[2] = 16'hE000;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.sample_tick = 1'b0;
    bus.cfg_we = 1'b0;
    bus.cfg_ch = '0;
    bus.cfg_step = '0;
    bus.cfg_en = 1'b0;
    bus.ovr_clr = 1'b0;
    core_mul = 16'h0000;
    core_add = 16'h1000;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("rst_mix_out", bus.mix_out, 16'h0000);
    check("rst_mix_valid", bus.mix_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_overrun", bus.overrun, 1'b0);
    check("rst_core_phase", bus.core_phase, 16'hE000);

    cfg_write(0, 14'h0400, 1'b1);
    run_frame(0, 1'b0);
    check("tp_v0_ph", obs_ph[0], 16'hE000);
`ifdef MIX_SAT_EN
    check("tp_v0_mix", bus.mix_out, 16'h1000);
`else
    check("tp_v0_mix", bus.mix_out, 16'h0400);
`endif
    run_frame(0, 1'b0);
    check("tp_v0_ph2", obs_ph[0], 16'hE400);

    cfg_write(1, 14'h3FFF, 1'b1);
    run_frame(0, 1'b0);
    check("tp_v1_f1", obs_ph[1], 16'hE000);
    run_frame(0, 1'b0);
    check("tp_v1_f2", obs_ph[1], 16'h1FFF);
    run_frame(0, 1'b0);
    check("tp_v1_f3", obs_ph[1], 16'h1FFE);

    run_frame(5, 1'b0);
    check("ovr_set", bus.overrun, 1'b1);
    repeat (5) @(negedge clk);
    check("ovr_hold", bus.overrun, 1'b1);
    bus.ovr_clr = 1'b1;
    @(negedge clk);
    bus.ovr_clr = 1'b0;
    check("ovr_clr", bus.overrun, 1'b0);

    cfg_write(2, 14'h0123, 1'b1);
    run_frame(0, 1'b0);
    run_frame(0, 1'b1);
    run_frame(0, 1'b0);
    check("dis_v2_ph", obs_ph[2], 16'hE000);

    // Reset mid-frame: no mix_valid may follow.
    @(negedge clk);
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    begin
      int seen;
      seen = 0;
      repeat (40) begin
        @(negedge clk);
        if (bus.mix_valid === 1'b1) seen++;
      end
      check("abort_no_valid", seen, 0);
    end
    check("abort_busy", bus.busy, 1'b0);
    check("abort_core_phase", bus.core_phase, 16'hE000);
    check("abort_mix_out", bus.mix_out, 16'h0000);

    for (int it = 0; it < 16; it++) begin
      core_mul = 16'($urandom);
      core_add = 16'($urandom);
      for (int w = 0; w < int'($urandom_range(0, 2)); w++)
        cfg_write(int'($urandom_range(0, N_CH - 1)), 14'($urandom_range(0, 16383)), ($urandom_range(0, 3) != 0));
      run_frame(0, 1'b0);
    end

    for (int v = 0; v < N_CH; v++) cfg_write(v, 14'h0100, 1'b1);
    core_mul = 16'h0000;
    core_add = 16'h2000;
    run_frame(0, 1'b0);
`ifdef MIX_SAT_EN
    check("all_pos", bus.mix_out, 16'h7FFF);
`else
    check("all_pos", bus.mix_out, 16'h2000);
`endif
    core_add = 16'hE000;
    run_frame(0, 1'b0);
`ifdef MIX_SAT_EN
    check("all_neg", bus.mix_out, 16'h8000);
`else
    check("all_neg", bus.mix_out, 16'hE000);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
